// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register ids,
// fetch FSM state type and small decode helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_OUT  = 2'd1,
    S_PC   = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  // Instruction carries a register-specifier byte.
  function automatic logic need_regids_f(input logic [3:0] ic);
    case (ic)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:  return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  // Instruction carries an 8-byte constant word.
  function automatic logic need_valc_f(input logic [3:0] ic);
    case (ic)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Legal icode/ifun combination.
  function automatic logic ifun_ok_f(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      I_RRMOVQ, I_JXX: return (fn <= 4'd6);
      I_OPQ:           return (fn <= 4'd3);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ: return (fn == 4'd0);
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational instruction splitter: carves the 10-byte memory window at
// pc into icode/ifun/ra/rb/valC and computes the sequential next PC.
module fetch_align
  import y86_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [79:0] rdata,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [63:0] valp,
  output logic        need_regids,
  output logic        need_valc,
  output logic        instr_valid
);

  // Field extraction; absent registers read as REG_NONE, absent constant as 0.
  always_comb begin
    icode       = rdata[7:4];
    ifun        = rdata[3:0];
    need_regids = need_regids_f(icode);
    need_valc   = need_valc_f(icode);
    instr_valid = ifun_ok_f(icode, ifun);
    ra          = REG_NONE;
    rb          = REG_NONE;
    if (need_regids) begin
      ra = rdata[15:12];
      rb = rdata[11:8];
    end
    valc = '0;
    if (need_valc) begin
      valc = need_regids ? rdata[79:16] : rdata[71:8];
    end
    valp = pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 SEQ fetch stage: owns the PC, requests instruction memory, registers
// the decoded fields for the decode handshake and waits for the PC update.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [79:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [63:0] valp,
  output logic [2:0]  stat,
  output logic [63:0] pc,
  input  logic        pc_upd_valid,
  input  logic [63:0] pc_upd
);

  localparam logic [31:0] WD_LIMIT = ACK_TIMEOUT;

  fetch_state_t state;
  logic [31:0]  wd;

  logic [3:0]  al_icode;
  logic [3:0]  al_ifun;
  logic [3:0]  al_ra;
  logic [3:0]  al_rb;
  logic [63:0] al_valc;
  logic [63:0] al_valp;
  logic        al_instr_valid;
  // Length flags are already folded into al_valp by the aligner.
  logic [1:0]  al_len_flags_unused;

  logic        timeout;
  logic [2:0]  good_stat;

  fetch_align u_align (
    .pc          (pc),
    .rdata       (imem_rdata),
    .icode       (al_icode),
    .ifun        (al_ifun),
    .ra          (al_ra),
    .rb          (al_rb),
    .valc        (al_valc),
    .valp        (al_valp),
    .need_regids (al_len_flags_unused[1]),
    .need_valc   (al_len_flags_unused[0]),
    .instr_valid (al_instr_valid)
  );

  assign imem_addr = pc;

  // Watchdog expiry and status for a clean memory response.
  always_comb begin
    timeout   = (ACK_TIMEOUT != 0) && (wd == WD_LIMIT);
    good_stat = STAT_AOK;
    if (!al_instr_valid)        good_stat = STAT_INS;
    else if (al_icode == I_HALT) good_stat = STAT_HLT;
  end

  // Fetch FSM with PC, watchdog and registered decode outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      wd         <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      icode      <= 4'h0;
      ifun       <= 4'h0;
      ra         <= REG_NONE;
      rb         <= REG_NONE;
      valc       <= '0;
      valp       <= '0;
      stat       <= STAT_AOK;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            // first cycle after reset release: raise the request
            imem_req <= 1'b1;
          end else if (imem_err || timeout) begin
            imem_req   <= 1'b0;
            wd         <= '0;
            inst_valid <= 1'b1;
            icode      <= 4'h0;
            ifun       <= 4'h0;
            ra         <= REG_NONE;
            rb         <= REG_NONE;
            valc       <= '0;
            valp       <= pc;
            stat       <= STAT_ADR;
            state      <= S_OUT;
          end else if (imem_ack) begin
            imem_req   <= 1'b0;
            wd         <= '0;
            inst_valid <= 1'b1;
            icode      <= al_icode;
            ifun       <= al_ifun;
            ra         <= al_ra;
            rb         <= al_rb;
            valc       <= al_valc;
            valp       <= al_valp;
            stat       <= good_stat;
            state      <= S_OUT;
          end else begin
            wd <= wd + 32'd1;
          end
        end
        S_OUT: begin
          if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            state      <= (stat == STAT_AOK) ? S_PC : S_HALT;
          end
        end
        S_PC: begin
          if (pc_upd_valid) begin
            pc       <= pc_upd;
            imem_req <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_HALT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory responder driven from tasks,
// expected decode results queued at response time and compared on accept.
module tb_fetch_stage;
  import y86_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_err = 1'b0;
  logic [79:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp, pc;
  logic [2:0]  stat;
  logic        pc_upd_valid = 1'b0;
  logic [63:0] pc_upd = '0;

  always #5 clock = ~clock;

  fetch_stage #(.RESET_PC(64'h0), .ACK_TIMEOUT(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_err     (imem_err),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .icode        (icode),
    .ifun         (ifun),
    .ra           (ra),
    .rb           (rb),
    .valc         (valc),
    .valp         (valp),
    .stat         (stat),
    .pc           (pc),
    .pc_upd_valid (pc_upd_valid),
    .pc_upd       (pc_upd)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [63:0] c, input logic [63:0] p,
                              input logic [2:0] s);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.ra = a; e.rb = b;
    e.valc = c; e.valp = p; e.stat = s;
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check_eq({tag, ".icode"}, 64'(icode), 64'(e.icode));
    check_eq({tag, ".ifun"},  64'(ifun),  64'(e.ifun));
    check_eq({tag, ".ra"},    64'(ra),    64'(e.ra));
    check_eq({tag, ".rb"},    64'(rb),    64'(e.rb));
    check_eq({tag, ".valc"},  valc,       e.valc);
    check_eq({tag, ".valp"},  valp,       e.valp);
    check_eq({tag, ".stat"},  64'(stat),  64'(e.stat));
  endtask

  // Called at a negedge; waits (bounded) for the request and checks its address.
  task automatic wait_req(input string tag, input logic [63:0] addr);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, ".req"},  64'(imem_req), 64'd1);
    check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  // Answers the outstanding request after lat cycles.
  task automatic respond(input string tag, input logic [79:0] data, input int lat,
                         input logic ack_v, input logic err_v);
    repeat (lat) @(posedge clock);
    #1;
    imem_rdata = data;
    imem_ack   = ack_v;
    imem_err   = err_v;
    @(negedge clock);
    check_eq({tag, ".valid_early"}, 64'(inst_valid), 64'd0);
    @(posedge clock);
    #1;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = '0;
    @(negedge clock);
  endtask

  // Waits for inst_valid, holds ready low for hold cycles, then accepts and
  // compares against the scoreboard head.
  task automatic consume(input string tag, input int hold, input logic bogus_upd);
    int   n = 0;
    exp_t e;
    while (inst_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, ".valid"}, 64'(inst_valid), 64'd1);
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd0, 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, ".hold_valid"}, 64'(inst_valid), 64'd1);
      check_fields({tag, ".hold"}, e);
      @(negedge clock);
    end
    inst_ready = 1'b1;
    if (bogus_upd) begin
      pc_upd_valid = 1'b1;
      pc_upd       = 64'h999;
    end
    check_fields(tag, e);
    @(posedge clock);
    #1;
    inst_ready   = 1'b0;
    pc_upd_valid = 1'b0;
    @(negedge clock);
    check_eq({tag, ".valid_drop"}, 64'(inst_valid), 64'd0);
  endtask

  task automatic pc_update(input logic [63:0] v);
    pc_upd       = v;
    pc_upd_valid = 1'b1;
    @(posedge clock);
    #1;
    pc_upd_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".req"},   64'(imem_req),   64'd0);
    check_eq({tag, ".valid"}, 64'(inst_valid), 64'd0);
    check_eq({tag, ".pc"},    pc,              64'h0);
    check_fields(tag, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1));
  endtask

  initial begin
    int n;
    int busy;
    // Reset state
    repeat (2) @(negedge clock);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // irmovq with constant, ack two cycles after request
    wait_req("t1", 64'h0);
    sb.push_back(mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h123456789ABCDEF0, 64'd10, 3'd1));
    respond("t1", 80'h1234_5678_9ABC_DEF0_F330, 2, 1'b1, 1'b0);
    consume("t1", 0, 1'b0);
    pc_update(64'h40);

    // addq with back-pressure; bogus pc update in the accept cycle is ignored
    wait_req("t2", 64'h40);
    sb.push_back(mk(4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h42, 3'd1));
    respond("t2", 80'h0160, 1, 1'b1, 1'b0);
    consume("t2", 3, 1'b1);
    pc_update(64'h42);
    wait_req("t2b", 64'h42);

    // cmovg (ifun 6) is legal
    sb.push_back(mk(4'h2, 4'h6, 4'h0, 4'h1, 64'h0, 64'h44, 3'd1));
    respond("t4c", 80'h0126, 1, 1'b1, 1'b0);
    consume("t4c", 0, 1'b0);
    pc_update(64'h44);
    wait_req("t4a_req", 64'h44);

    // icode C is invalid
    sb.push_back(mk(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h45, 3'd4));
    respond("t4a", 80'h00C0, 1, 1'b1, 1'b0);
    consume("t4a", 0, 1'b0);

    // Reset during S_REQ with a late ack in the reset cycle
    apply_reset();
    wait_req("t6a_pre", 64'h0);
    imem_ack   = 1'b1;
    imem_rdata = 80'h0010;
    reset_n    = 1'b0;
    #1;
    check_reset_vals("t6a");
    @(posedge clock);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("t6a.ack_ignored", 64'(inst_valid), 64'd0);
    wait_req("t6a_post", 64'h0);

    // rrmovq with ifun 7 is invalid
    sb.push_back(mk(4'h2, 4'h7, 4'h0, 4'h0, 64'h0, 64'h2, 3'd4));
    respond("t4b", 80'h0027, 1, 1'b1, 1'b0);
    consume("t4b", 0, 1'b0);

    // halt, then stay idle regardless of pc update pulses
    apply_reset();
    wait_req("t3_req", 64'h0);
    sb.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd2));
    respond("t3", 80'h0000, 1, 1'b1, 1'b0);
    consume("t3", 0, 1'b0);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      pc_upd       = 64'h80;
      pc_upd_valid = (i % 2 == 0);
      @(negedge clock);
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) busy++;
    end
    pc_upd_valid = 1'b0;
    check_eq("t3.halt_idle", 64'(busy), 64'd0);
    check_eq("t3.stat_hold", 64'(stat), 64'd2);

    // Reset during S_OUT
    apply_reset();
    wait_req("t6b_req", 64'h0);
    sb.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd1));
    respond("t6b", 80'h0010, 1, 1'b1, 1'b0);
    check_eq("t6b.valid_before", 64'(inst_valid), 64'd1);
    check_eq("t6b.valp_before", valp, 64'h1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("t6b");
    void'(sb.pop_front());
    @(negedge clock);
    reset_n = 1'b1;
    wait_req("t6b_post", 64'h0);

    // err together with ack
    sb.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3));
    respond("t5a", 80'h0010, 1, 1'b1, 1'b1);
    consume("t5a", 0, 1'b0);

    // no response: watchdog forces an ADR fault
    apply_reset();
    wait_req("t5b_req", 64'h0);
    n = 0;
    while (inst_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_eq("t5b.latency", 64'(n), 64'd9);
    check_fields("t5b", mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running required finished");
    $fatal(1);
  end

endmodule
